// File: rtl/data_sram_slave.sv
// Data-SRAM responder: byte-masked stores, loads captured at accept, responses returned in order after LATENCY cycles.
// addr_ok drops only while QDEPTH requests are outstanding and none pops in the same cycle.
module data_sram_slave #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2,
  parameter int QDEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [3:0]  wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam int DEPTH = 1 << ADDR_W;

  typedef struct packed {
    logic        isStore;
    logic [31:0] data;
    logic [1:0]  timer;
  } entry_t;

  if (LATENCY < 1 || LATENCY > 4) begin : gBadLatency
    $error("data_sram_slave: LATENCY=%0d outside legal range 1..4", LATENCY);
  end
  if (QDEPTH < 1 || QDEPTH > 4) begin : gBadQdepth
    $error("data_sram_slave: QDEPTH=%0d outside legal range 1..4", QDEPTH);
  end
  if (ADDR_W < 1 || ADDR_W > 30) begin : gBadAddrW
    $error("data_sram_slave: ADDR_W=%0d outside legal range 1..30", ADDR_W);
  end

  logic [31:0]       mem [DEPTH];
  entry_t            q    [QDEPTH];
  entry_t            qNxt [QDEPTH];
  logic [PTR_W-1:0]  rdPtr, wrPtr, rdPtrNxt, wrPtrNxt;
  logic [CNT_W-1:0]  count, countNxt;
  logic              dataOkNxt;
  logic [31:0]       rdataNxt;
  logic              accept;
  logic              isStore;
  logic [ADDR_W-1:0] wordIdx;
  logic              unusedAddr;

  // Upper address bits alias and addr[1:0] is ignored; lanes come from wen alone.
  assign wordIdx    = addr[ADDR_W+1:2];
  assign unusedAddr = ^{addr[31:ADDR_W+2], addr[1:0]};
  assign isStore    = |wen;

  assign addr_ok = req & rst & ((count < CNT_W'(QDEPTH)) | data_ok);
  assign accept  = addr_ok;

  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < QDEPTH; i++) begin
      qNxt[i] = q[i];
      if (q[i].timer != 2'd0) qNxt[i].timer = q[i].timer - 2'd1;
    end
    rdPtrNxt = data_ok ? ptrInc(rdPtr) : rdPtr;
    wrPtrNxt = wrPtr;
    countNxt = count;
    if (accept) begin
      qNxt[wrPtr].isStore = isStore;
      qNxt[wrPtr].data    = mem[wordIdx];
      qNxt[wrPtr].timer   = 2'(LATENCY - 1);
      wrPtrNxt            = ptrInc(wrPtr);
    end
    case ({accept, data_ok})
      2'b10:   countNxt = count + CNT_W'(1);
      2'b01:   countNxt = count - CNT_W'(1);
      default: countNxt = count;
    endcase
    // Look at next cycle's head so data_ok/rdata can be registered.
    dataOkNxt = (countNxt != '0) && (qNxt[rdPtrNxt].timer == 2'd0);
    rdataNxt  = rdata;
    if (dataOkNxt) rdataNxt = qNxt[rdPtrNxt].isStore ? 32'h0 : qNxt[rdPtrNxt].data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < QDEPTH; i++) q[i] <= '0;
      rdPtr   <= '0;
      wrPtr   <= '0;
      count   <= '0;
      data_ok <= 1'b0;
      rdata   <= 32'h0;
    end else begin
      for (int i = 0; i < QDEPTH; i++) q[i] <= qNxt[i];
      rdPtr   <= rdPtrNxt;
      wrPtr   <= wrPtrNxt;
      count   <= countNxt;
      data_ok <= dataOkNxt;
      rdata   <= rdataNxt;
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < 4; k++) begin
        if (wen[k]) mem[wordIdx][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_sram_slave.sv
// Bench for data_sram_slave: default instance checked against a due-cycle response model,
// plus a QDEPTH=1/LATENCY=3 instance checked against a directed timeline.
module tb_data_sram_slave;

  localparam int LAT = 2;
  localparam int QD  = 2;
  localparam int AW  = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [3:0]  wen;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;

  logic        req2;
  logic [3:0]  wen2;
  logic [31:0] addr2, wdata2;
  logic        addr_ok2, data_ok2;
  logic [31:0] rdata2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;

  resp_t       pend[$];
  logic [31:0] refMem [int];

  always #5 clk = ~clk;

  data_sram_slave #(.ADDR_W(AW), .LATENCY(LAT), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst), .req(req), .wen(wen), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  data_sram_slave #(.ADDR_W(AW), .LATENCY(3), .QDEPTH(1)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .wen(wen2), .addr(addr2), .wdata(wdata2),
    .addr_ok(addr_ok2), .data_ok(data_ok2), .rdata(rdata2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle on the default instance: drive, check at negedge against the model, advance.
  task automatic step(input logic r, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                      output logic acc, output logic okObs, output logic dokObs, output logic [31:0] rdObs);
    logic        expDok, expOk;
    logic [31:0] m;
    int          idx;
    req = r; wen = w; addr = a; wdata = d;
    @(negedge clk);
    expDok = (pend.size() > 0) && (pend[0].due <= cyc);
    expOk  = r && ((pend.size() < QD) || expDok);
    chk("addr_ok", {31'h0, addr_ok}, {31'h0, expOk});
    chk("data_ok", {31'h0, data_ok}, {31'h0, expDok});
    okObs = addr_ok; dokObs = data_ok; rdObs = rdata;
    if (expDok) begin
      chk("rdata", rdata, pend[0].data);
      void'(pend.pop_front());
    end
    if (expOk) begin
      idx = int'(a[AW+1:2]);
      m   = refMem.exists(idx) ? refMem[idx] : 32'h0;
      if (w != 4'h0) begin
        for (int k = 0; k < 4; k++) if (w[k]) m[8*k +: 8] = d[8*k +: 8];
        refMem[idx] = m;
        pend.push_back('{due: cyc + LAT, data: 32'h0});
      end else begin
        pend.push_back('{due: cyc + LAT, data: m});
      end
    end
    acc = expOk;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    logic acc, ok, dok;
    logic [31:0] rd;
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 32'h0, 32'h0, acc, ok, dok, rd);
  endtask

  task automatic xfer(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    logic acc, ok, dok;
    logic [31:0] rd;
    acc = 1'b0;
    for (int n = 0; n < 10 && !acc; n++) step(1'b1, w, a, d, acc, ok, dok, rd);
  endtask

  task automatic xfer2(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    logic got;
    got  = 1'b0;
    req2 = 1'b1; wen2 = w; addr2 = a; wdata2 = d;
    for (int n = 0; n < 8 && !got; n++) begin
      @(negedge clk);
      got = addr_ok2;
      @(posedge clk); #1;
    end
    req2 = 1'b0;
    checks++;
    assert (got === 1'b1) else begin
      failures++;
      $error("FAIL xfer2_accept observed=%b expected=1", got);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc, ok, dok, haveReq;
    logic [31:0] rd, ha, hd, w0, w1;
    logic [3:0]  hw;
    logic        okT  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        dokT [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int          idx;

    // Reset state with a request already presented
    rst = 1'b0; req = 1'b1; wen = 4'h0; addr = 32'h0; wdata = 32'h0;
    req2 = 1'b0; wen2 = 4'h0; addr2 = 32'h0; wdata2 = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_addr_ok", {31'h0, addr_ok}, 32'h0);
    chk("reset_data_ok", {31'h0, data_ok}, 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1; req = 1'b0;
    cyc = 0;

    // Preload words 0..15, 0x40 and 0x100
    for (int i = 0; i < 16; i++) xfer(4'hF, 32'(i * 4), $urandom());
    xfer(4'hF, 32'h40, 32'hDEADBEEF);
    xfer(4'hF, 32'h100, 32'hAABBCCDD);
    idle(3);

    // Single load, response exactly LATENCY cycles after acceptance
    step(1'b1, 4'h0, 32'h40, 32'h0, acc, ok, dok, rd);
    chk("t1_accept", {31'h0, ok}, 32'h1);
    step(1'b0, 4'h0, 32'h0, 32'h0, acc, ok, dok, rd);
    chk("t1_early", {31'h0, dok}, 32'h0);
    step(1'b0, 4'h0, 32'h0, 32'h0, acc, ok, dok, rd);
    chk("t1_resp", {31'h0, dok}, 32'h1);
    chk("t1_rdata", rd, 32'hDEADBEEF);
    step(1'b0, 4'h0, 32'h0, 32'h0, acc, ok, dok, rd);
    chk("t1_once", {31'h0, dok}, 32'h0);

    // Partial store then immediate load of the same word
    step(1'b1, 4'b0101, 32'h100, 32'h11223344, acc, ok, dok, rd);
    step(1'b1, 4'b0000, 32'h100, 32'h0, acc, ok, dok, rd);
    step(1'b0, 4'h0, 32'h0, 32'h0, acc, ok, dok, rd);
    chk("t2_store_resp", {31'h0, dok}, 32'h1);
    chk("t2_store_rdata", rd, 32'h0);
    step(1'b0, 4'h0, 32'h0, 32'h0, acc, ok, dok, rd);
    chk("t2_load_resp", {31'h0, dok}, 32'h1);
    chk("t2_merge", rd, 32'hAA22CC44);
    idle(1);

    // Back-to-back loads at full throughput
    for (int i = 0; i < 6; i++) begin
      step(i < 4, 4'h0, 32'(4 * (i % 4)), 32'h0, acc, ok, dok, rd);
      if (i < 4) chk("t3_accept", {31'h0, ok}, 32'h1);
      if (i >= 2) begin
        chk("t3_resp", {31'h0, dok}, 32'h1);
        chk("t3_order", rd, refMem[i - 2]);
      end
    end
    idle(1);

    // Upper address bits alias onto the same word
    for (int i = 0; i < 4; i++) begin
      step(i < 2, 4'h0, (i == 0) ? 32'h4000_0010 : 32'h0000_0010, 32'h0, acc, ok, dok, rd);
      if (i >= 2) chk("alias_rdata", rd, refMem[4]);
    end
    idle(1);

    // Reset with two loads outstanding
    step(1'b1, 4'h0, 32'h20, 32'h0, acc, ok, dok, rd);
    step(1'b1, 4'h0, 32'h24, 32'h0, acc, ok, dok, rd);
    req = 1'b1; addr = 32'h2C;
    #2 rst = 1'b0;
    #1;
    chk("midrst_addr_ok", {31'h0, addr_ok}, 32'h0);
    chk("midrst_data_ok", {31'h0, data_ok}, 32'h0);
    chk("midrst_rdata", rdata, 32'h0);
    pend.delete();
    @(posedge clk); #1;
    rst = 1'b1; req = 1'b0;
    cyc++;
    idle(4);
    step(1'b1, 4'h0, 32'h28, 32'h0, acc, ok, dok, rd);
    step(1'b0, 4'h0, 32'h0, 32'h0, acc, ok, dok, rd);
    step(1'b0, 4'h0, 32'h0, 32'h0, acc, ok, dok, rd);
    chk("postrst_resp", {31'h0, dok}, 32'h1);
    chk("postrst_rdata", rd, refMem[10]);

    // Random mix of loads and partial stores, requests held until accepted
    haveReq = 1'b0; hw = 4'h0; ha = 32'h0; hd = 32'h0;
    for (int n = 0; n < 300; n++) begin
      if (!haveReq && $urandom_range(0, 3) != 0) begin
        idx = int'($urandom_range(0, 16));
        ha  = ($urandom() & 32'hFFFF_C003) | 32'(idx << 2);
        hw  = ($urandom_range(0, 2) == 0) ? 4'(($urandom_range(1, 15))) : 4'h0;
        hd  = $urandom();
        haveReq = 1'b1;
      end
      step(haveReq, hw, ha, hd, acc, ok, dok, rd);
      if (acc) haveReq = 1'b0;
    end
    idle(4);

    // QDEPTH=1, LATENCY=3 instance: stall until the first response pops
    w0 = $urandom(); w1 = $urandom();
    xfer2(4'hF, 32'h0, w0);
    xfer2(4'hF, 32'h4, w1);
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) begin
      req2 = (i < 4); wen2 = 4'h0; addr2 = (i == 0) ? 32'h0 : 32'h4; wdata2 = 32'h0;
      @(negedge clk);
      chk($sformatf("q1_addr_ok[%0d]", i), {31'h0, addr_ok2}, {31'h0, okT[i]});
      chk($sformatf("q1_data_ok[%0d]", i), {31'h0, data_ok2}, {31'h0, dokT[i]});
      if (i == 3) chk("q1_rdata_first", rdata2, w0);
      if (i == 6) chk("q1_rdata_second", rdata2, w1);
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
